// File: rtl/bf2i_bundle_ctrl_if.sv
// rtl/bf2i_bundle_ctrl_if.sv - bundle input/output handshake and sideband interface
// Purpose: groups the upstream bundle handshake and the downstream
//          output handshake/sideband of the BF2I bundle controller.
// Signals:
//   in_valid  upstream bundle present
//   in_sof    bundle is first of a frame (qualified by in_valid)
//   in_ready  controller accepts a bundle this cycle
//   out_valid butterfly output register holds a valid bundle
//   out_ready downstream accepts the output bundle
//   out_sof   output bundle is index 0
//   out_eof   output bundle is the last index of the frame
//   out_bidx  bundle index of the output bundle
// Modports: slave = controller side, master = upstream/downstream side.
interface bf2i_bundle_ctrl_if #(
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic             in_sof;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic             out_eof;
  logic [CNT_W-1:0] out_bidx;

  modport slave (
    input  in_valid, in_sof, out_ready,
    output in_ready, out_valid, out_sof, out_eof, out_bidx
  );

  modport master (
    output in_valid, in_sof, out_ready,
    input  in_ready, out_valid, out_sof, out_eof, out_bidx
  );
endinterface

// File: rtl/bf2i_bundle_ctrl.sv
// rtl/bf2i_bundle_ctrl.sv - frame sequencer and flow controller for the BF2I stage
// Purpose: accepts bundles with valid/ready, drives the butterfly register
//          enable and produces a sideband aligned with the butterfly output.
// Ports:
//   clk, rst_n  stage clock, asynchronous active-low reset
//   bus         bf2i_bundle_ctrl_if.slave handshake and output sideband
//   bf_en       combinational register enable to the butterfly
//   busy        frame in progress or output valid
//   sof_err     one-cycle pulse: sof accepted while a frame was running
//   frame_done  one-cycle pulse after the eof beat is transferred
//   frame_cnt   completed frames (only with BF2I_CTRL_STATS_EN)
//   drop_cnt    bundles dropped while idle (only with BF2I_CTRL_STATS_EN)
// Optional feature macro: BF2I_CTRL_STATS_EN (statistics counters).
module bf2i_bundle_ctrl #(
  parameter  int NUM_BUNDLES = 32,
  parameter  int STAT_W      = 16,
  localparam int CNT_W       = $clog2(NUM_BUNDLES)
) (
  input  logic                clk,
  input  logic                rst_n,
  bf2i_bundle_ctrl_if.slave   bus,
  output logic                bf_en,
  output logic                busy,
  output logic                sof_err,
  output logic                frame_done
`ifdef BF2I_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0]   frame_cnt,
  output logic [STAT_W-1:0]   drop_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BUNDLES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic             r_out_sof;
  logic             r_out_eof;
  logic [CNT_W-1:0] r_out_bidx;
  logic             r_sof_err;
  logic             r_frame_done;

  logic             w_in_ready;
  logic             w_acc;
  logic             w_fwd;
  logic             w_drop;
  logic             w_serr;
  logic [CNT_W-1:0] w_bidx;

  // rst_n gates in_ready so upstream sees no acceptance while held in reset.
  assign w_in_ready = rst_n & (~r_out_valid | bus.out_ready);
  assign w_acc      = bus.in_valid & w_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_fwd       = 1'b0;
    w_drop      = 1'b0;
    w_serr      = 1'b0;
    w_bidx      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (bus.in_sof) begin
            w_fwd       = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            // Orphan bundle: consumed so upstream never stalls, but not forwarded.
            w_drop = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_acc) begin
          w_fwd = 1'b1;
          if (bus.in_sof) begin
            // Restart: the truncated frame never sees eof or frame_done.
            w_serr = 1'b1;
          end else begin
            w_bidx = r_cnt + CNT_W'(1);
            if (w_bidx == LAST_IDX) begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_sof    <= 1'b0;
      r_out_eof    <= 1'b0;
      r_out_bidx   <= '0;
      r_sof_err    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sof_err    <= w_serr;
      r_frame_done <= r_out_valid & bus.out_ready & r_out_eof;
      if (w_fwd) begin
        r_cnt       <= w_bidx;
        r_out_valid <= 1'b1;
        r_out_sof   <= (w_bidx == '0);
        r_out_eof   <= (w_bidx == LAST_IDX);
        r_out_bidx  <= w_bidx;
      end else if (bus.out_ready) begin
        // Sideband keeps its last value; consumers qualify with out_valid.
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef BF2I_CTRL_STATS_EN
  logic [STAT_W-1:0] r_frame_cnt;
  logic [STAT_W-1:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (r_frame_done && (r_frame_cnt != '1)) begin
        r_frame_cnt <= r_frame_cnt + STAT_W'(1);
      end
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + STAT_W'(1);
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sof   = r_out_sof;
  assign bus.out_eof   = r_out_eof;
  assign bus.out_bidx  = r_out_bidx;
  assign bf_en         = w_fwd;
  assign busy          = (r_state == S_RUN) | r_out_valid;
  assign sof_err       = r_sof_err;
  assign frame_done    = r_frame_done;

endmodule
